// File: rtl/eei_initiator.sv
// Core-side EEI custom-instruction initiator: latches a decoded instruction, issues the
// EEI request, waits for ack or timeout, then retires none/single/batch writes.
module eei_initiator #(
    parameter int RS_MAX  = 8,
    parameter int RD_MAX  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           dec_valid,
    input  logic                           dec_ext,
    input  logic [2:0]                     dec_funct3,
    input  logic [6:0]                     dec_funct7,
    input  logic [4:0]                     dec_rd,
    input  logic [4:0]                     dec_batch_start,
    input  logic [4:0]                     dec_batch_len,
    input  logic [RS_MAX-1:0][31:0]        dec_rs_val,
    output logic                           stall_o,
    output logic                           done_o,
    output logic                           exc_o,
    output logic                           exc_cause_o,
    output logic                           rf_we_o,
    output logic [4:0]                     rf_waddr_o,
    output logic [31:0]                    rf_wdata_o,
    output logic                           eei_req,
    output logic                           eei_ext,
    output logic [2:0]                     eei_funct3,
    output logic [6:0]                     eei_funct7,
    output logic [4:0]                     eei_batch_start,
    output logic [4:0]                     eei_batch_len,
    output logic [RS_MAX-1:0][31:0]        eei_rs_val,
    input  logic                           eei_ack,
    input  logic                           eei_error,
    input  logic [1:0]                     eei_rd_op,
    input  logic [4:0]                     eei_rd_len,
    input  logic [RD_MAX-1:0][31:0]        eei_rd_val
);
    typedef enum logic [1:0] {IDLE, REQ, WB, RESP} state_t;

    localparam int CW = $clog2(TIMEOUT + 2);
    localparam int KW = (RD_MAX > 1) ? $clog2(RD_MAX) : 1;

    state_t                 r_state, w_next;
    logic                   r_ext;
    logic [2:0]             r_f3;
    logic [6:0]             r_f7;
    logic [4:0]             r_rd, r_bstart, r_blen;
    logic [RS_MAX-1:0][31:0] r_rs;
    logic [CW-1:0]          r_cnt;
    logic [RD_MAX-1:0][31:0] r_rdv;
    logic                   r_batch;
    logic [5:0]             r_n;
    logic [KW-1:0]          r_k;
    logic                   r_exc, r_cause;

    logic [5:0]             w_n;
    logic                   w_to, w_last;
    logic [4:0]             w_waddr;

    // Batch count clamped to the number of result slots actually returned
    assign w_n     = ({1'b0, eei_rd_len} > 6'(RD_MAX)) ? 6'(RD_MAX) : {1'b0, eei_rd_len};
    assign w_to    = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT - 1));
    assign w_last  = !r_batch || (6'(r_k) == r_n - 6'd1);
    assign w_waddr = r_batch ? (r_bstart + 5'(r_k)) : r_rd;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (dec_valid) w_next = REQ;
            REQ: begin
                if (eei_ack) begin
                    if (eei_error || eei_rd_op == 2'd3 || eei_rd_op == 2'd0) w_next = RESP;
                    else if (eei_rd_op == 2'd1 || w_n != 6'd0)              w_next = WB;
                    else                                                     w_next = RESP;
                end else if (w_to) begin
                    w_next = RESP;
                end
            end
            WB:      if (w_last) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= IDLE;
            r_ext    <= 1'b0;
            r_f3     <= '0;
            r_f7     <= '0;
            r_rd     <= '0;
            r_bstart <= '0;
            r_blen   <= '0;
            r_rs     <= '0;
            r_cnt    <= '0;
            r_rdv    <= '0;
            r_batch  <= 1'b0;
            r_n      <= '0;
            r_k      <= '0;
            r_exc    <= 1'b0;
            r_cause  <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: if (dec_valid) begin
                    r_ext    <= dec_ext;
                    r_f3     <= dec_funct3;
                    r_f7     <= dec_funct7;
                    r_rd     <= dec_rd;
                    r_bstart <= dec_batch_start;
                    r_blen   <= dec_batch_len;
                    r_rs     <= dec_rs_val;
                    r_cnt    <= '0;
                    r_k      <= '0;
                    r_exc    <= 1'b0;
                    r_cause  <= 1'b0;
                end
                REQ: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (eei_ack) begin
                        // Results are only trusted in the ack cycle
                        r_rdv   <= eei_rd_val;
                        r_batch <= (eei_rd_op == 2'd2);
                        r_n     <= w_n;
                        r_exc   <= eei_error || (eei_rd_op == 2'd3);
                        r_cause <= 1'b0;
                    end else if (w_to) begin
                        r_exc   <= 1'b1;
                        r_cause <= 1'b1;
                    end
                end
                WB:      if (!w_last) r_k <= r_k + KW'(1);
                default: ;
            endcase
        end
    end

    assign eei_req         = (r_state == REQ);
    assign eei_ext         = r_ext;
    assign eei_funct3      = r_f3;
    assign eei_funct7      = r_f7;
    assign eei_batch_start = r_bstart;
    assign eei_batch_len   = r_blen;
    assign eei_rs_val      = r_rs;

    // x0 writes are swallowed but still take their cycle
    assign rf_we_o     = (r_state == WB) && (w_waddr != 5'd0);
    assign rf_waddr_o  = (r_state == WB) ? w_waddr : 5'd0;
    assign rf_wdata_o  = (r_state == WB) ? r_rdv[r_k] : 32'd0;

    assign done_o      = (r_state == RESP) && !r_exc;
    assign exc_o       = (r_state == RESP) && r_exc;
    assign exc_cause_o = (r_state == RESP) && r_exc && r_cause;
    assign stall_o     = (r_state == REQ) || (r_state == WB) || (r_state == IDLE && dec_valid);
endmodule

// File: tb/tb_eei_initiator.sv
// Directed bench for eei_initiator: inputs driven and outputs sampled on the falling edge.
module tb_eei_initiator;
    localparam int RS_MAX = 8, RD_MAX = 8, TIMEOUT = 64;

    logic clk = 1'b0, rst_n = 1'b0;
    logic dec_valid = 0, dec_ext = 0;
    logic [2:0] dec_funct3 = 0;
    logic [6:0] dec_funct7 = 0;
    logic [4:0] dec_rd = 0, dec_batch_start = 0, dec_batch_len = 0;
    logic [RS_MAX-1:0][31:0] dec_rs_val = '0;
    logic stall, done, exc, cause, we;
    logic [4:0] waddr;
    logic [31:0] wdata;
    logic req, e_ext;
    logic [2:0] e_f3;
    logic [6:0] e_f7;
    logic [4:0] e_bs, e_bl;
    logic [RS_MAX-1:0][31:0] e_rs;
    logic ack = 0, err = 0;
    logic [1:0] rd_op = 0;
    logic [4:0] rd_len = 0;
    logic [RD_MAX-1:0][31:0] rd_val = '0;

    int total = 0, bad = 0;
    logic [36:0] wq[$];

    always #5 clk = ~clk;

    eei_initiator #(.RS_MAX(RS_MAX), .RD_MAX(RD_MAX), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rst_ni(rst_n), .dec_valid(dec_valid), .dec_ext(dec_ext),
        .dec_funct3(dec_funct3), .dec_funct7(dec_funct7), .dec_rd(dec_rd),
        .dec_batch_start(dec_batch_start), .dec_batch_len(dec_batch_len), .dec_rs_val(dec_rs_val),
        .stall_o(stall), .done_o(done), .exc_o(exc), .exc_cause_o(cause),
        .rf_we_o(we), .rf_waddr_o(waddr), .rf_wdata_o(wdata),
        .eei_req(req), .eei_ext(e_ext), .eei_funct3(e_f3), .eei_funct7(e_f7),
        .eei_batch_start(e_bs), .eei_batch_len(e_bl), .eei_rs_val(e_rs),
        .eei_ack(ack), .eei_error(err), .eei_rd_op(rd_op), .eei_rd_len(rd_len), .eei_rd_val(rd_val));

    // Write log; write-port outputs depend on state only, so falling-edge sampling is race-free
    always @(negedge clk) if (we) wq.push_back({waddr, wdata});

    task automatic issue(input logic [4:0] rd, input logic [4:0] bs, input logic [6:0] f7);
        @(negedge clk);
        dec_valid = 1; dec_ext = 1; dec_funct3 = 3'd5; dec_funct7 = f7;
        dec_rd = rd; dec_batch_start = bs; dec_batch_len = 5'd3;
        for (int i = 0; i < RS_MAX; i++) dec_rs_val[i] = 32'hA000_0000 + i;
    endtask

    task automatic test_reset;
        #1;
        total++; if ({stall, done, exc, cause, we, req, e_f7, waddr, wdata} !== '0) begin
            bad++; $display("FAIL reset_outputs got=%h exp=0", {stall, done, exc, cause, we, req, e_f7, waddr, wdata}); end
        @(negedge clk); rst_n = 1;
    endtask

    task automatic test_nowrite;
        wq.delete();
        issue(5'd3, 5'd0, 7'h05);
        #1; total++; if (stall !== 1'b1) begin bad++; $display("FAIL nw_stall_dec got=%b exp=1", stall); end
        @(negedge clk); dec_valid = 0; dec_rs_val = '1; dec_funct7 = 7'h7F;
        total++; if (req !== 1'b1 || e_ext !== 1'b1 || e_f7 !== 7'h05 || e_f3 !== 3'd5) begin
            bad++; $display("FAIL nw_req got=%b/%b/%h/%h exp=1/1/05/5", req, e_ext, e_f7, e_f3); end
        total++; if (e_rs[2] !== 32'hA000_0002) begin bad++; $display("FAIL nw_rs_latched got=%h exp=a0000002", e_rs[2]); end
        ack = 1; rd_op = 2'd0;
        @(negedge clk); ack = 0;
        dec_valid = 1; dec_funct7 = 7'h22;  // presented during RESP: must be ignored here
        #1; total++; if (done !== 1'b1 || exc !== 1'b0 || req !== 1'b0 || stall !== 1'b0) begin
            bad++; $display("FAIL nw_done got=%b%b%b%b exp=1000", done, exc, req, stall); end
        @(negedge clk);
        #1; total++; if (req !== 1'b0 || done !== 1'b0 || stall !== 1'b1) begin
            bad++; $display("FAIL b2b_idle got=%b%b%b exp=001", req, done, stall); end
        @(negedge clk); dec_valid = 0;
        total++; if (req !== 1'b1 || e_f7 !== 7'h22) begin bad++; $display("FAIL b2b_req got=%b/%h exp=1/22", req, e_f7); end
        ack = 1; rd_op = 2'd0;
        @(negedge clk); ack = 0;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_done got=%b exp=1", done); end
        total++; if (wq.size() != 0) begin bad++; $display("FAIL nw_nowrites got=%0d exp=0", wq.size()); end
    endtask

    task automatic test_single;
        wq.delete();
        issue(5'd5, 5'd0, 7'h40);
        @(negedge clk); dec_valid = 0;
        @(negedge clk);
        @(negedge clk);
        total++; if (req !== 1'b1 || stall !== 1'b1) begin bad++; $display("FAIL sw_req3 got=%b%b exp=11", req, stall); end
        ack = 1; rd_op = 2'd1; rd_val[0] = 32'hDEAD_BEEF;
        @(negedge clk); ack = 0; rd_val[0] = 32'h1234_5678;
        #1; total++; if (we !== 1'b1 || waddr !== 5'd5 || wdata !== 32'hDEAD_BEEF || stall !== 1'b1 || req !== 1'b0) begin
            bad++; $display("FAIL sw_write got=%b/%0d/%h/%b/%b exp=1/5/deadbeef/1/0", we, waddr, wdata, stall, req); end
        @(negedge clk);
        #1; total++; if (done !== 1'b1 || stall !== 1'b0 || we !== 1'b0) begin
            bad++; $display("FAIL sw_done got=%b%b%b exp=100", done, stall, we); end
        total++; if (wq.size() != 1) begin bad++; $display("FAIL sw_count got=%0d exp=1", wq.size()); end
    endtask

    task automatic test_batch_wrap;
        logic [4:0] ea[4];
        logic ew[4];
        ea[0] = 5'd30; ea[1] = 5'd31; ea[2] = 5'd0; ea[3] = 5'd1;
        ew[0] = 1; ew[1] = 1; ew[2] = 0; ew[3] = 1;
        issue(5'd0, 5'd30, 7'h41);
        @(negedge clk); dec_valid = 0;
        ack = 1; rd_op = 2'd2; rd_len = 5'd4;
        for (int i = 0; i < RD_MAX; i++) rd_val[i] = 32'h10 + i;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) begin ack = 0; rd_val = '1; end
            #1; total++;
            if (we !== ew[i] || (ew[i] && (waddr !== ea[i] || wdata !== 32'h10 + i))) begin
                bad++; $display("FAIL bw_write%0d got=%b/%0d/%h exp=%b/%0d/%h", i, we, waddr, wdata, ew[i], ea[i], 32'h10 + i); end
        end
        @(negedge clk);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL bw_done got=%b exp=1", done); end
    endtask

    task automatic test_clamp;
        int n;
        wq.delete();
        issue(5'd0, 5'd8, 7'h42);
        @(negedge clk); dec_valid = 0;
        ack = 1; rd_op = 2'd2; rd_len = 5'd12;
        for (int i = 0; i < RD_MAX; i++) rd_val[i] = 32'h100 + i;
        n = 0;
        do begin @(negedge clk); ack = 0; n++; end while (!done && n < 40);
        total++; if (n != 9) begin bad++; $display("FAIL cl_latency got=%0d exp=9", n); end
        total++; if (wq.size() != 8) begin bad++; $display("FAIL cl_count got=%0d exp=8", wq.size()); end
        for (int i = 0; i < wq.size() && i < 8; i++) begin
            total++; if (wq[i] !== {5'(8 + i), 32'h100 + i}) begin
                bad++; $display("FAIL cl_entry%0d got=%h exp=%h", i, wq[i], {5'(8 + i), 32'h100 + i}); end
        end
        wq.delete();
        issue(5'd0, 5'd8, 7'h42);
        @(negedge clk); dec_valid = 0;
        ack = 1; rd_op = 2'd2; rd_len = 5'd0;
        @(negedge clk); ack = 0;
        total++; if (done !== 1'b1 || wq.size() != 0) begin
            bad++; $display("FAIL cl_zero got=%b/%0d exp=1/0", done, wq.size()); end
    endtask

    task automatic test_errors;
        for (int t = 0; t < 2; t++) begin
            wq.delete();
            issue(5'd7, 5'd0, 7'h43);
            @(negedge clk); dec_valid = 0;
            ack = 1; err = (t == 0); rd_op = (t == 0) ? 2'd1 : 2'd3; rd_val[0] = 32'h55;
            @(negedge clk); ack = 0; err = 0;
            #1; total++; if (exc !== 1'b1 || cause !== 1'b0 || done !== 1'b0 || we !== 1'b0) begin
                bad++; $display("FAIL err%0d_resp got=%b%b%b%b exp=1000", t, exc, cause, done, we); end
            @(negedge clk);
            total++; if (wq.size() != 0 || exc !== 1'b0) begin bad++; $display("FAIL err%0d_after got=%0d/%b exp=0/0", t, wq.size(), exc); end
        end
    endtask

    task automatic test_timeout;
        int n;
        issue(5'd9, 5'd0, 7'h44);
        @(negedge clk); dec_valid = 0;
        n = 0;
        while (req && n < 200) begin n++; @(negedge clk); end
        total++; if (n != TIMEOUT) begin bad++; $display("FAIL to_cycles got=%0d exp=%0d", n, TIMEOUT); end
        total++; if (exc !== 1'b1 || cause !== 1'b1 || done !== 1'b0) begin
            bad++; $display("FAIL to_exc got=%b%b%b exp=110", exc, cause, done); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        issue(5'd0, 5'd2, 7'h45);
        @(negedge clk); dec_valid = 0;
        ack = 1; rd_op = 2'd2; rd_len = 5'd4;
        for (int i = 0; i < RD_MAX; i++) rd_val[i] = 32'h200 + i;
        @(negedge clk); ack = 0;
        @(negedge clk); rst_n = 0;
        #1; total++; if ({stall, done, exc, we, req, waddr, wdata, e_f7} !== '0) begin
            bad++; $display("FAIL rm_outputs got=%h exp=0", {stall, done, exc, we, req, waddr, wdata, e_f7}); end
        wq.delete();
        @(negedge clk); rst_n = 1;
        repeat (3) @(negedge clk);
        total++; if (wq.size() != 0 || done !== 1'b0) begin bad++; $display("FAIL rm_quiet got=%0d/%b exp=0/0", wq.size(), done); end
        issue(5'd11, 5'd0, 7'h46);
        @(negedge clk); dec_valid = 0;
        total++; if (req !== 1'b1 || e_f7 !== 7'h46) begin bad++; $display("FAIL rm_next_req got=%b/%h exp=1/46", req, e_f7); end
        ack = 1; rd_op = 2'd1; rd_val[0] = 32'hCAFE;
        @(negedge clk); ack = 0;
        #1; total++; if (we !== 1'b1 || waddr !== 5'd11 || wdata !== 32'hCAFE) begin
            bad++; $display("FAIL rm_next_write got=%b/%0d/%h exp=1/11/0000cafe", we, waddr, wdata); end
        @(negedge clk);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL rm_next_done got=%b exp=1", done); end
    endtask

    initial begin
        test_reset();
        test_nowrite();
        test_single();
        test_batch_wrap();
        test_clamp();
        test_errors();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
